// File: rtl/silu_seq_pkg.sv
// rtl/silu_seq_pkg.sv - shared types and helpers for the SiLU LUT sequencer
// Purpose: sequencer state encoding and the element-counter width helper.
// Ports: none (package).
package silu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-element vector still needs a one-bit counter so the
    // indexed selects stay legal.
    function automatic int idx_width(input int num_parallel);
        return (num_parallel > 1) ? $clog2(num_parallel) : 1;
    endfunction

endpackage

// File: rtl/silu_lut_sequencer_if.sv
// rtl/silu_lut_sequencer_if.sv - stream and LUT port bundle for the sequencer
// Purpose: groups the input stream, output stream and shared-LUT port.
// Ports:
//   data_in_0 / data_in_0_valid / data_in_0_ready    : input vector stream
//   data_out_0 / data_out_0_valid / data_out_0_ready : result vector stream
//   lut_addr / lut_data                               : shared combinational LUT
// Modports: slave = sequencer side, master = producer/consumer/LUT side.
interface silu_lut_sequencer_if #(
    parameter int DATA_WIDTH   = 4,
    parameter int NUM_PARALLEL = 4
) ();

    logic [NUM_PARALLEL*DATA_WIDTH-1:0] data_in_0;
    logic                               data_in_0_valid;
    logic                               data_in_0_ready;
    logic [NUM_PARALLEL*DATA_WIDTH-1:0] data_out_0;
    logic                               data_out_0_valid;
    logic                               data_out_0_ready;
    logic [DATA_WIDTH-1:0]              lut_addr;
    logic [DATA_WIDTH-1:0]              lut_data;

    modport slave (
        input  data_in_0,
        input  data_in_0_valid,
        output data_in_0_ready,
        output data_out_0,
        output data_out_0_valid,
        input  data_out_0_ready,
        output lut_addr,
        input  lut_data
    );

    modport master (
        output data_in_0,
        output data_in_0_valid,
        input  data_in_0_ready,
        input  data_out_0,
        input  data_out_0_valid,
        output data_out_0_ready,
        input  lut_addr,
        output lut_data
    );

endinterface

// File: rtl/silu_lut4.sv
// rtl/silu_lut4.sv - 4-bit SiLU lookup table, shared between sequencers
// Purpose: combinational SiLU map; address and data are signed Q2.2.
// Ports:
//   addr : input  [3:0] signed Q2.2 argument
//   data : output [3:0] signed Q2.2 result, rounded to nearest
module silu_lut4 (
    input  logic [3:0] addr,
    output logic [3:0] data
);

    always_comb begin
        data = 4'h0;
        case (addr)
            4'h0: data = 4'h0;
            4'h1: data = 4'h1;
            4'h2: data = 4'h1;
            4'h3: data = 4'h2;
            4'h4: data = 4'h3;
            4'h5: data = 4'h4;
            4'h6: data = 4'h5;
            4'h7: data = 4'h6;
            // The negative lobe of SiLU bottoms out near -0.28, which
            // rounds to -0.25 for every argument except -0.25 itself.
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: data = 4'hF;
            4'hF: data = 4'h0;
            default: data = 4'h0;
        endcase
    end

endmodule

// File: rtl/silu_lut_sequencer.sv
// rtl/silu_lut_sequencer.sv - time-multiplexes one activation LUT across a vector
// Purpose: captures a NUM_PARALLEL-element vector, walks it through the
//   external LUT one element per cycle, then presents the result vector.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : stream in/out plus shared LUT port (silu_lut_sequencer_if.slave)
//   busy : high while elements are being looked up
module silu_lut_sequencer
    import silu_seq_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int NUM_PARALLEL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    silu_lut_sequencer_if.slave  bus,
    output logic                 busy
);

    localparam int IDX_WIDTH = idx_width(NUM_PARALLEL);
    localparam int VEC_WIDTH = NUM_PARALLEL * DATA_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_PARALLEL - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [IDX_WIDTH-1:0]   idx_q;
    logic [VEC_WIDTH-1:0]   inbuf_q;
    logic [VEC_WIDTH-1:0]   result_q;
    logic                   last_elem;
    logic                   accept;

    assign last_elem = (idx_q == LAST_IDX);
    assign accept    = bus.data_in_0_valid && bus.data_in_0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.data_in_0_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_elem) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Output handshake with a waiting input skips IDLE.
                if (bus.data_out_0_ready) begin
                    state_d = bus.data_in_0_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.data_in_0_ready  = 1'b0;
        bus.data_out_0_valid = 1'b0;
        bus.data_out_0       = '0;
        bus.lut_addr         = '0;
        busy                 = 1'b0;
        // Gating on rst keeps every output quiet during the reset cycle
        // even though the state register only clears on the edge.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    bus.data_in_0_ready = 1'b1;
                end
                RUN: begin
                    busy         = 1'b1;
                    bus.lut_addr = inbuf_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
                end
                DONE: begin
                    bus.data_out_0_valid = 1'b1;
                    bus.data_out_0       = result_q;
                    bus.data_in_0_ready  = bus.data_out_0_ready;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            inbuf_q  <= '0;
            result_q <= '0;
        end else if (accept) begin
            inbuf_q <= bus.data_in_0;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            result_q[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] <= bus.lut_data;
            idx_q <= last_elem ? '0 : idx_q + IDX_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_silu_lut_sequencer.sv
// tb/tb_silu_lut_sequencer.sv - self-checking bench for silu_lut_sequencer
module tb_silu_lut_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic busy4;
    logic busy1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [15:0] stim_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    silu_lut_sequencer_if #(.DATA_WIDTH(4), .NUM_PARALLEL(4)) b4 ();
    silu_lut_sequencer_if #(.DATA_WIDTH(4), .NUM_PARALLEL(1)) b1 ();

    silu_lut4 u_lut4 (.addr(b4.lut_addr), .data(b4.lut_data));
    silu_lut4 u_lut1 (.addr(b1.lut_addr), .data(b1.lut_data));

    silu_lut_sequencer #(.DATA_WIDTH(4), .NUM_PARALLEL(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .bus  (b4),
        .busy (busy4)
    );

    silu_lut_sequencer #(.DATA_WIDTH(4), .NUM_PARALLEL(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (b1),
        .busy (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // SiLU on a signed Q2.2 argument, rounded half away from zero.
    function automatic logic [3:0] silu_ref(input logic [3:0] a);
        real x;
        real y;
        int  q;
        x = real'($signed(a)) / 4.0;
        y = x / (1.0 + $exp(-x)) * 4.0;
        q = (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(0.5 - y);
        return q[3:0];
    endfunction

    function automatic logic [15:0] ref_vec(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = silu_ref(v[i*4 +: 4]);
        return r;
    endfunction

    task automatic run_stream(input int nvec, input bit rand_flow, input bit chk_spacing);
        logic [15:0] exp_q[$];
        int          acc_cyc[$];
        int          got = 0;
        int          sent = 0;
        int          budget = 0;
        bit          pending = 0;
        bit          stall = 0;
        logic [15:0] held = '0;
        b4.data_in_0_valid = 1'b0;
        while (got < nvec && budget < 1000) begin
            @(negedge clk);
            budget++;
            if (!pending) begin
                if (sent < nvec && (!rand_flow || $urandom_range(3) != 0)) begin
                    b4.data_in_0 = (stim_q.size() > 0) ? stim_q.pop_front() : 16'($urandom);
                    b4.data_in_0_valid = 1'b1;
                    pending = 1;
                end else begin
                    b4.data_in_0_valid = 1'b0;
                end
            end
            b4.data_out_0_ready = rand_flow ? ($urandom_range(2) != 0) : 1'b1;
            #1;
            if (stall) begin
                check("hold_valid", b4.data_out_0_valid, 1);
                check("hold_data", b4.data_out_0, held);
            end
            if (b4.data_in_0_valid && b4.data_in_0_ready) begin
                exp_q.push_back(ref_vec(b4.data_in_0));
                acc_cyc.push_back(cyc);
                sent++;
                pending = 0;
            end
            if (b4.data_out_0_valid && b4.data_out_0_ready) begin
                check("out_has_expect", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("stream_data", b4.data_out_0, exp_q.pop_front());
                got++;
            end
            stall = b4.data_out_0_valid && !b4.data_out_0_ready;
            held  = b4.data_out_0;
        end
        check("stream_done", got, nvec);
        if (chk_spacing) begin
            for (int i = 1; i < acc_cyc.size(); i++)
                check("accept_spacing", acc_cyc[i] - acc_cyc[i-1], 5);
        end
        b4.data_in_0_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] basic_in;
        logic [3:0]  x;
        logic [3:0]  prev;
        bit          have_prev;
        int          spurious;

        rst = 1'b1;
        b4.data_in_0 = '0;
        b4.data_in_0_valid = 1'b0;
        b4.data_out_0_ready = 1'b0;
        b1.data_in_0 = '0;
        b1.data_in_0_valid = 1'b0;
        b1.data_out_0_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", b4.data_out_0_valid, 0);
        check("rst_busy", busy4, 0);
        check("rst_lut_addr", b4.lut_addr, 0);
        check("rst_in_ready", b4.data_in_0_ready, 0);
        check("rst_data", b4.data_out_0, 0);
        rst = 1'b0;
        #1;
        check("idle_ready", b4.data_in_0_ready, 1);

        // Basic vector plus LUT address walk.
        basic_in = 16'hF873;
        @(negedge clk);
        b4.data_in_0 = basic_in;
        b4.data_in_0_valid = 1'b1;
        b4.data_out_0_ready = 1'b0;
        @(negedge clk);
        b4.data_in_0_valid = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            check("run_lut_addr", b4.lut_addr, basic_in[k*4 +: 4]);
            check("run_busy", busy4, 1);
            check("run_valid_low", b4.data_out_0_valid, 0);
            check("run_in_ready", b4.data_in_0_ready, 0);
        end
        @(negedge clk);
        #1;
        check("basic_valid", b4.data_out_0_valid, 1);
        check("basic_data", b4.data_out_0, 16'h0F62);
        check("done_busy", busy4, 0);
        check("done_lut_addr", b4.lut_addr, 0);

        // Backpressure with a competing input offered.
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(negedge clk);
            end
            b4.data_in_0 = 16'hAAAA;
            b4.data_in_0_valid = 1'b1;
            #1;
            check("bp_valid", b4.data_out_0_valid, 1);
            check("bp_data", b4.data_out_0, 16'h0F62);
            check("bp_in_ready", b4.data_in_0_ready, 0);
        end
        b4.data_in_0_valid = 1'b0;
        b4.data_out_0_ready = 1'b1;
        #1;
        check("bp_release_ready", b4.data_in_0_ready, 1);
        @(negedge clk);
        #1;
        check("bp_idle_valid", b4.data_out_0_valid, 0);
        check("bp_idle_ready", b4.data_in_0_ready, 1);
        check("bp_idle_busy", busy4, 0);

        // Back-to-back directed vectors.
        stim_q.push_back(16'h1245);
        stim_q.push_back(16'h609E);
        check("b2b_ref0", ref_vec(16'h1245), 16'h1134);
        check("b2b_ref1", ref_vec(16'h609E), 16'h50FF);
        run_stream(2, 1'b0, 1'b1);

        // Reset in the second RUN cycle.
        @(negedge clk);
        b4.data_in_0 = 16'h3C5A;
        b4.data_in_0_valid = 1'b1;
        b4.data_out_0_ready = 1'b1;
        @(negedge clk);
        b4.data_in_0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_valid", b4.data_out_0_valid, 0);
        check("mid_rst_busy", busy4, 0);
        check("mid_rst_lut_addr", b4.lut_addr, 0);
        check("mid_rst_in_ready", b4.data_in_0_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", b4.data_in_0_ready, 1);
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (b4.data_out_0_valid) spurious++;
        end
        check("no_stale_output", spurious, 0);
        run_stream(1, 1'b0, 1'b0);

        // Random stream with random gaps and backpressure.
        run_stream(24, 1'b1, 1'b0);

        // Single-element build, back-to-back.
        have_prev = 0;
        prev = '0;
        b1.data_out_0_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            x = (k == 0) ? 4'b0100 : 4'($urandom);
            b1.data_in_0 = x;
            b1.data_in_0_valid = 1'b1;
            #1;
            if (have_prev) begin
                check("np1_valid", b1.data_out_0_valid, 1);
                check("np1_data", b1.data_out_0, silu_ref(prev));
            end else begin
                check("np1_idle_ready", b1.data_in_0_ready, 1);
            end
            check("np1_accept_ready", b1.data_in_0_ready, 1);
            @(negedge clk);
            b1.data_in_0_valid = 1'b0;
            #1;
            check("np1_busy", busy1, 1);
            check("np1_lut_addr", b1.lut_addr, x);
            check("np1_valid_low", b1.data_out_0_valid, 0);
            if (k == 0) check("np1_ref_0100", silu_ref(x), 4'b0011);
            prev = x;
            have_prev = 1;
        end
        @(negedge clk);
        #1;
        check("np1_last_valid", b1.data_out_0_valid, 1);
        check("np1_last_data", b1.data_out_0, silu_ref(prev));
        @(negedge clk);
        #1;
        check("np1_idle_after", b1.data_out_0_valid, 0);
        check("np1_busy_after", busy1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/silu_lut_sequencer.md
Name: silu_lut_sequencer

Overview:
Time-multiplexes one shared combinational activation LUT (4-bit SiLU map) across a NUM_PARALLEL-wide vector. It sits between a parallel stream producer and consumer, both using valid/ready handshakes. It captures one vector, presents one element per cycle on the LUT address port, collects the results, then emits the whole vector. This trades throughput for LUT area.

Parameters:
DATA_WIDTH, 4, bits per element; equals the LUT address and data width.
NUM_PARALLEL, 4, elements per vector; must be 1 or more.
IDX_WIDTH, (NUM_PARALLEL>1 ? $clog2(NUM_PARALLEL) : 1), element counter width (derived; do not override).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
data_in_0  input  NUM_PARALLEL*DATA_WIDTH  input vector; element i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
data_in_0_valid  input  1  input vector valid.
data_in_0_ready  output  1  sequencer can accept a vector.
data_out_0  output  NUM_PARALLEL*DATA_WIDTH  result vector, same packing as the input.
data_out_0_valid  output  1  result vector valid.
data_out_0_ready  input  1  consumer accepts the result.
lut_addr  output  DATA_WIDTH  address driven to the external shared LUT.
lut_data  input  DATA_WIDTH  LUT result; combinational from lut_addr, same cycle.
busy  output  1  high in RUN state.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, idx=0, input buffer=0, result buffer=0.
- Outputs under reset: data_out_0_valid=0, data_out_0=0, busy=0, lut_addr=0. data_in_0_ready is forced to 0 while rst=1.
- Reset mid-RUN or mid-DONE abandons the vector; no partial output is ever emitted.
- States: IDLE, RUN, DONE (2-bit enum).
- IDLE:
  - data_in_0_ready=1.
  - On data_in_0_valid: capture data_in_0 into the input buffer, idx<=0, go to RUN.
- RUN:
  - lut_addr = inbuf[idx].
  - Each cycle: result[idx] <= lut_data.
  - If idx==NUM_PARALLEL-1: go to DONE and set idx<=0. Otherwise idx<=idx+1.
  - data_in_0_ready=0 and busy=1 throughout.
- DONE:
  - data_out_0_valid=1; data_out_0 = result buffer, held stable until the handshake completes.
  - data_in_0_ready = data_out_0_ready, so back-to-back transfer is allowed.
  - On data_out_0_ready=1 with data_in_0_valid=1: capture the new vector and go straight to RUN; no IDLE bubble.
  - On data_out_0_ready=1 with data_in_0_valid=0: go to IDLE.
  - On data_out_0_ready=0: stay in DONE; valid and data must not change.
- lut_addr is 0 outside RUN.
- Timing: input handshake in cycle t gives RUN in cycles t+1 to t+NUM_PARALLEL, and data_out_0_valid first high in cycle t+NUM_PARALLEL+1.
- Sustained throughput: one vector per NUM_PARALLEL+1 cycles.
- NUM_PARALLEL=1: RUN lasts exactly one cycle.
- No arithmetic is performed on elements; values pass through unchanged in width.
- idx never exceeds NUM_PARALLEL-1; no wrap-around occurs inside RUN.
- A data_in_0_valid held high during RUN is not accepted.
- A deasserted data_in_0_valid in DONE does not block output.

Decomposition:
- Shared package silu_seq_pkg holds:
  - the state typedef enum {IDLE, RUN, DONE};
  - a helper function computing IDX_WIDTH.
- The LUT stays external, so multiple sequencers or a later arbiter can share it.
- The testbench instantiates the existing 4-bit SiLU LUT module connected to lut_addr/lut_data.
- No internal sub-module is needed; the counter and FSM stay inline.

Test Plan:
- Basic vector: NUM_PARALLEL=4, data_in_0 = {4'b1111, 4'b1000, 4'b0111, 4'b0011} (element 3 down to 0) -> data_out_0 = {4'b0000, 4'b1111, 4'b0110, 4'b0010}. data_out_0_valid rises exactly 5 cycles after the accept.
- LUT address sequence: with the same input, lut_addr over RUN cycles = 0011, 0111, 1000, 1111. busy is high for exactly 4 cycles.
- Backpressure: hold data_out_0_ready=0 for 6 cycles in DONE -> valid stays 1, data_out_0 stable, data_in_0_ready=0. Assert ready -> one transfer, then IDLE.
- Back-to-back: valid high continuously with vectors {0001,0010,0100,0101} then {0110,0000,1001,1110} -> outputs {0001,0001,0011,0100} and {0101,0000,1111,1111}. Accepts are spaced exactly 5 cycles apart.
- Reset mid-RUN: assert rst in the 2nd RUN cycle -> next cycle valid=0, busy=0, lut_addr=0. After release, a fresh vector processes correctly and the old vector is never output.
- NUM_PARALLEL=1 build: input 4'b0100 -> output 4'b0011, valid 2 cycles after accept.
